// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: two-master arbiter for the shared memory/IO port with fixed wait cycles.
// Define MIO_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module mio_bus_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_be,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_ready,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [AW-1:0]   dma_addr,
    input  logic [DW-1:0]   dma_wdata,
    input  logic [DW/8-1:0] dma_be,
    output logic [DW-1:0]   dma_rdata,
    output logic            dma_ready,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      grant
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] LOAD = 4'(WAIT - 1);
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_dma, r_we;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata, r_cpu_rdata, r_dma_rdata;
    logic [DW/8-1:0]   r_be;
    logic              w_start, w_pick_dma;
    assign w_start = (r_state == IDLE) && (cpu_req || dma_req);
`ifdef MIO_ARB_RR_EN
    logic r_last_dma;
    // On a tie, the master that did not win the previous grant goes first.
    assign w_pick_dma = dma_req && (!cpu_req || !r_last_dma);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_last_dma <= 1'b1;
        else if (w_start) r_last_dma <= w_pick_dma;
    end
`else
    assign w_pick_dma = dma_req && !cpu_req;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state == IDLE   ? (w_start ? ACCESS : IDLE) :
                    r_state == ACCESS ? (r_cnt == 4'd0 ? RESP : ACCESS) : IDLE;
        mem_en    = r_state == ACCESS;
        mem_we    = mem_en && r_we;
        grant     = mem_en ? (r_dma ? 2'b10 : 2'b01) : 2'b00;
        cpu_ready = (r_state == RESP) && !r_dma;
        dma_ready = (r_state == RESP) && r_dma;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_dma       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if (w_start) begin
            r_cnt   <= LOAD;
            r_dma   <= w_pick_dma;
            r_we    <= w_pick_dma ? dma_we    : cpu_we;
            r_addr  <= w_pick_dma ? dma_addr  : cpu_addr;
            r_wdata <= w_pick_dma ? dma_wdata : cpu_wdata;
            r_be    <= w_pick_dma ? dma_be    : cpu_be;
        end else if (r_state == ACCESS) begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd0 && !r_we && r_dma) r_dma_rdata <= mem_rdata;
            if (r_cnt == 4'd0 && !r_we && !r_dma) r_cpu_rdata <= mem_rdata;
        end
    end
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed checks of the arbiter at WAIT=2 (u_dut) and WAIT=1 (u_dut1).
module tb_mio_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0, mem_rdata = '0;
    logic [3:0]  cpu_be = '0, dma_be = '0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, dma_ready, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [1:0]  grant;
    logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
    logic        cpu_ready1, dma_ready1, mem_en1, mem_we1;
    logic [3:0]  mem_be1;
    logic [1:0]  grant1;
    int          n_vec = 0, n_err = 0;
    bit          rr;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.AW(32), .DW(32), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    mio_bus_arbiter #(.AW(32), .DW(32), .WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata1), .cpu_ready(cpu_ready1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_rdata(dma_rdata1), .dma_ready(dma_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_be(mem_be1),
        .mem_rdata(mem_rdata), .grant(grant1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MIO_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", cpu_rdata, 0);
        tick();
        reset = 1'b1;
        tick();
        // CPU read at 0x100, WAIT=2
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_c1_en", mem_en, 1);
        chk("rd_c1_grant", grant, 2'b01);
        chk("rd_c1_addr", mem_addr, 32'h100);
        chk("rd_c1_we", mem_we, 0);
        tick();
        chk("rd_c2_en", mem_en, 1);
        chk("rd_c2_ready", cpu_ready, 0);
        tick();
        chk("rd_c3_ready", cpu_ready, 1);
        chk("rd_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_c3_dma_ready", dma_ready, 0);
        chk("rd_c3_en", mem_en, 0);
        chk("rd_c3_grant", grant, 0);
        cpu_req = 1'b0;
        tick();
        chk("rd_c4_ready", cpu_ready, 0);
        // CPU write, partial byte enables
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0011; cpu_wdata = 32'h1234ABCD; cpu_addr = 32'h200;
        mem_rdata = 32'h0;
        tick();
        chk("wr_we", mem_we, 1);
        chk("wr_be", mem_be, 4'b0011);
        chk("wr_wdata", mem_wdata, 32'h1234ABCD);
        tick();
        tick();
        chk("wr_ready", cpu_ready, 1);
        chk("wr_rdata_held", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        // DMA read in flight, CPU request arrives in cycle 1
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300; mem_rdata = 32'hA5A5A5A5;
        tick();
        chk("dma_c1_grant", grant, 2'b10);
        chk("dma_c1_addr", mem_addr, 32'h300);
        cpu_req = 1'b1; cpu_addr = 32'h400;
        tick();
        chk("dma_c2_grant", grant, 2'b10);
        tick();
        chk("dma_c3_ready", dma_ready, 1);
        chk("dma_c3_rdata", dma_rdata, 32'hA5A5A5A5);
        chk("dma_c3_cpu_ready", cpu_ready, 0);
        chk("dma_c3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        dma_req = 1'b0;
        tick();
        chk("dma_c4_idle", grant, 0);
        tick();
        chk("dma_c5_cpu_grant", grant, 2'b01);
        chk("dma_c5_addr", mem_addr, 32'h400);
        tick();
        tick();
        chk("dma_c7_cpu_ready", cpu_ready, 1);
        cpu_req = 1'b0;
        tick();
        // reset in the middle of an access, both masters then pending
        cpu_req = 1'b1; mem_rdata = 32'h11112222;
        tick();
        chk("ra_c1_en", mem_en, 1);
        dma_req = 1'b1;
        reset = 1'b0;
        #1;
        chk("ra_en", mem_en, 0);
        chk("ra_grant", grant, 0);
        chk("ra_addr", mem_addr, 0);
        chk("ra_rdata", cpu_rdata, 0);
        chk("ra_dma_rdata", dma_rdata, 0);
        tick();
        chk("ra_no_ready", {cpu_ready, dma_ready}, 0);
        reset = 1'b1;
        // both held for four transfers; first tie after reset goes to the CPU
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("tie%0d_grant", k), grant, (rr && k[0]) ? 2'b10 : 2'b01);
            tick();
            tick();
            chk($sformatf("tie%0d_ready", k), {dma_ready, cpu_ready}, (rr && k[0]) ? 2'b10 : 2'b01);
            if (k == 3) begin
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
            tick();
        end
        // WAIT=1 DMA read on the second instance
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; mem_rdata = 32'h55;
        tick();
        chk("w1_c1_en", mem_en1, 1);
        chk("w1_c1_grant", grant1, 2'b10);
        chk("w1_c1_ready", dma_ready1, 0);
        tick();
        chk("w1_c2_ready", dma_ready1, 1);
        chk("w1_c2_rdata", dma_rdata1, 32'h55);
        chk("w1_c2_en", mem_en1, 0);
        dma_req = 1'b0;
        tick();
        chk("w1_c3_ready", dma_ready1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Shares the single memory/IO port between the multi-cycle CPU controller's memory interface and a second bus master (DMA/display fetch). Arbitrates between two requesters, holds the memory port for a fixed number of wait cycles, captures read data, and returns a one-cycle ready pulse. The CPU ready output drives the controller's `MIO_ready` input. The CPU request is the controller's `MemRead | MemWrite`.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width (byte enables are `DW/8` bits).
- `WAIT`, 2: memory access cycles per transfer, legal range 1..15.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `cpu_req` input 1: CPU access request; held until `cpu_ready`.
- `cpu_we` input 1: 1 = write.
- `cpu_addr` input AW: byte address.
- `cpu_wdata` input DW: write data.
- `cpu_be` input DW/8: byte enables.
- `cpu_rdata` output DW: last CPU read data.
- `cpu_ready` output 1: one-cycle completion pulse (to `MIO_ready`).
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_be`: second master, same meanings as the CPU port.
- `dma_rdata` output DW, `dma_ready` output 1: same meanings as the CPU port.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: memory write.
- `mem_addr` output AW, `mem_wdata` output DW, `mem_be` output DW/8: registered copies of the granted request.
- `mem_rdata` input DW: memory read data; valid in the last `mem_en` cycle.
- `grant` output 2: `01` = CPU owns the port, `10` = DMA owns the port, `00` = idle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, pick a winner.
  - Latch the winner's we/addr/wdata/be into the mem_* registers.
  - Set `grant`, load the wait counter with WAIT-1, and go to ACCESS.
- ACCESS:
  - `mem_en=1`.
  - `mem_we` is the latched we.
  - The counter decrements each cycle.
  - When the counter reaches 0:
    - On a read, sample `mem_rdata` into the winner's rdata register.
    - Go to RESP.
- RESP:
  - The winner's ready is 1 for exactly this cycle.
  - `mem_en=0`, `mem_we=0`, `grant` is cleared.
  - Next state is IDLE.
- Request inputs are sampled only in IDLE. Changes during ACCESS/RESP are ignored; the latched request completes.
- If a requester drops req mid-access, the transfer still completes and its ready still pulses.
- `cpu_rdata`/`dma_rdata` hold their value until that port's next read completes. Writes do not modify them.
- Arbitration when only one request is present: that requester wins.
- Arbitration when both requests are present: see Configuration.
- A requester still asserting req in the IDLE cycle after RESP is treated as a new request.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = IDLE.
  - All outputs are 0: both ready, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, both rdata, and `grant`.
  - `last_grant` = DMA.
- Reset asserted mid-access aborts the transfer immediately, with no ready pulse. After release the FSM restarts in IDLE.
- Latency, with a request seen in IDLE at cycle 0:
  - `mem_en` is high in cycles 1..WAIT.
  - Read data is captured at the end of cycle WAIT.
  - Ready is high in cycle WAIT+1, and rdata is valid in that same cycle.
- Back-to-back throughput: one transfer per WAIT+2 cycles. The IDLE cycle is mandatory between grants.
- WAIT=1 gives a single `mem_en` cycle, with capture in that cycle.

## Configuration
- `MIO_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests, the requester not in `last_grant` wins.
  - `last_grant` updates on every grant.
  - After reset the CPU wins the first tie.
- `MIO_ARB_RR_EN` undefined: fixed priority.
  - The CPU always wins ties.
  - The DMA is served only in an IDLE cycle with `cpu_req`=0.
  - The `last_grant` register is not implemented.

## Test plan
- CPU read, WAIT=2, `cpu_addr`=0x100, `mem_rdata`=0xDEADBEEF:
  - `mem_en` is high in cycles 1–2.
  - `cpu_ready` pulses in cycle 3 with `cpu_rdata`=0xDEADBEEF.
  - `dma_ready` stays 0.
- CPU write with `cpu_be`=4'b0011, `cpu_wdata`=0x1234ABCD:
  - In ACCESS, `mem_we`=1, `mem_be`=0011, `mem_wdata`=0x1234ABCD.
  - `cpu_rdata` is unchanged.
- Both requests held continuously for 4 transfers:
  - With RR_EN, `grant` sequence is CPU, DMA, CPU, DMA.
  - Without RR_EN, `grant` is CPU ×4 and `dma_ready` never pulses.
- DMA access in flight when `cpu_req` rises in cycle 1:
  - The DMA transfer completes unchanged.
  - The CPU is granted in the IDLE cycle after `dma_ready`.
- `reset`=0 asserted during ACCESS:
  - All outputs are 0 the same cycle, with no ready pulse.
  - After release, a pending `cpu_req` is granted and the CPU wins the first tie.
- WAIT=1 DMA read with `mem_rdata`=0x55:
  - `mem_en` is high for 1 cycle.
  - `dma_ready` pulses in cycle 2 with `dma_rdata`=0x55.
